cache_req_driver: RTL
=====================

// Module: cache_req_driver
// PURPOSE
//  Synthesizable CPU-side initiator for the L1 cache request port. The bench
//  loads scripted commands into an internal FIFO. The block drives
//  a/be/read/write/wd into the cache and holds each request through misses
//  until the cache signals a hit. It checks returned read data against
//  expected values and keeps hit, miss and error counts.
//  It sits between the test bench and the cache, in place of direct task-driven stimulus.
// PARAMETERS
//  DEPTH    16   command FIFO entries (power of 2, >=2)
//  TIMEOUT  256  max cycles in REQ or WAIT_RD before sticky timeout
//  CNT_W    16   width of hit/miss/error counters (saturating)
// PORTS
//  clk          in   1    clock, all state on posedge
//  reset        in   1    asynchronous, active-high reset
//  cmd_push     in   1    enqueue a command this cycle
//  cmd_write    in   1    1=write, 0=read
//  cmd_addr     in   32   byte address
//  cmd_be       in   4    byte enables
//  cmd_wd       in   32   write data
//  cmd_exp      in   32   expected read data
//  cmd_chk      in   1    compare read data when 1
//  cmd_full     out  1    FIFO holds DEPTH entries
//  a            out  32   to cache: address
//  be           out  4    to cache: byte enables
//  read         out  1    to cache: read request
//  write        out  1    to cache: write request
//  wd           out  32   to cache: write data
//  rd           in   32   from cache: read data
//  rd_valid     in   1    from cache: rd valid strobe
//  req_hit      in   1    from cache: current request hits / is accepted
//  req_miss     in   1    from cache: current request misses (fill in progress)
//  busy         out  1    state != IDLE or FIFO not empty
//  done         out  1    state==IDLE and FIFO empty
//  hit_cnt      out  CNT_W  requests accepted on hit
//  miss_cnt     out  CNT_W  requests seeing >=1 miss (counted once each)
//  err_cnt      out  CNT_W  read-data mismatches + spurious rd_valid
//  overflow     out  1    sticky: push while full
//  timeout      out  1    sticky: TIMEOUT exceeded
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, read=write=0, a/be/wd=0, counters=0,
//   overflow=timeout=0, done=1, busy=0. Reset mid-request drops read/write
//   asynchronously and discards queued commands.
//  FIFO: push while full is ignored and sets overflow, even if a pop
//   occurs in the same cycle. Pointers wrap mod DEPTH. Count range is 0..DEPTH.
//  State machine IDLE/REQ/WAIT_RD/ERR:
//   IDLE: if FIFO not empty, pop the head into the request regs. Next cycle
//    enter REQ with read or write asserted (one-cycle issue latency).
//   REQ: a/be/wd/read/write are held stable.
//    req_miss sampled: set the per-request missed flag and stay in REQ.
//     miss_cnt increments only on the first miss of the request.
//    req_hit sampled: hit_cnt++ and deassert read/write.
//     Write: go to IDLE.
//     Read with rd_valid in the same cycle: compare now, then go to IDLE.
//     Read otherwise: go to WAIT_RD.
//    req_hit and req_miss together: hit wins.
//   WAIT_RD: on rd_valid, compare (if chk) and go to IDLE.
//    Back-to-back: IDLE pops the next command in the cycle after returning.
//   ERR: entered from REQ or WAIT_RD after TIMEOUT cycles. Sets timeout,
//    drives read=write=0 and stays until reset. busy=1 and done=0 in ERR.
//  Compare: bytes i with be[i]=1 must match (rd[8i+7:8i]==exp[8i+7:8i]).
//   be=0 always passes. Any mismatch adds 1 to err_cnt.
//  rd_valid in IDLE or REQ (without req_hit) is a spurious strobe: err_cnt++.
//  All counters saturate at 2^CNT_W-1.
//  Timeout counter clears on every state entry.
// TESTING
//  1 Reset mid-REQ: read falls in the same cycle as reset; after release
//   done=1, counters=0.
//  2 Preload write 0x100=0xDEADBEEF be=F, then read 0x100 exp=0xDEADBEEF;
//   cache hits -> hit_cnt=2, err_cnt=0, done=1.
//  3 Read 0x4000 with miss for 5 cycles, then hit -> request held stable
//   6 cycles; miss_cnt=1, hit_cnt=1.
//  4 Read exp=0x11223344 be=0011 returns 0xFFFF3344 -> err_cnt=0;
//   the same read with be=1111 -> err_cnt=1.
//  5 Push 17 commands with DEPTH=16 and no pops -> cmd_full=1, overflow=1,
//   16 commands execute.
//  6 Cache never hits, TIMEOUT=256 -> timeout=1 at cycle 256 of REQ;
//   read=0, done=0 until reset.

Source files
------------

// File: rtl/cache_req_driver.sv
// cache_req_driver: CPU-side initiator for the L1 cache request port.
// Scripted commands are queued in a small FIFO. Each one is issued to the cache
// and held until the cache reports a hit. Returned read data is checked against
// the expected value, and hit/miss/error counts are kept.
module cache_req_driver #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_push,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [3:0]       cmd_be,
    input  logic [31:0]      cmd_wd,
    input  logic [31:0]      cmd_exp,
    input  logic             cmd_chk,
    output logic             cmd_full,
    output logic [31:0]      a,
    output logic [3:0]       be,
    output logic             read,
    output logic             write,
    output logic [31:0]      wd,
    input  logic [31:0]      rd,
    input  logic             rd_valid,
    input  logic             req_hit,
    input  logic             req_miss,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             overflow,
    output logic             timeout
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FCNT_W = $clog2(DEPTH + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(DEPTH);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2,
        ERR     = 2'd3
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp_data;
        logic        chk;
    } cmd_t;

    cmd_t              fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              fifo_empty;
    logic              push_ok;
    logic              pop;
    cmd_t              head;

    state_t            state;
    state_t            state_next;
    logic              req_wr;
    logic [31:0]       req_exp;
    logic              req_chk;
    logic              missed;
    logic [TMO_W-1:0]  tmo_cnt;

    logic              hit_evt;
    logic              miss_evt;
    logic              cmp_evt;
    logic              spur_evt;
    logic              err_evt;

    // Byte-lane compare: only enabled lanes take part, so be=0 never mismatches.
    function automatic logic data_mismatch(input logic [31:0] got,
                                           input logic [31:0] want,
                                           input logic [3:0]  en);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (en[i] && (got[8*i +: 8] != want[8*i +: 8])) bad = 1'b1;
        end
        return bad;
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign fifo_empty = (fifo_cnt == '0);
    assign cmd_full   = (fifo_cnt == FIFO_FULL);
    assign push_ok    = cmd_push && !cmd_full;
    assign head       = fifo_mem[rd_ptr];
    assign busy       = (state != IDLE) || !fifo_empty;
    assign done       = !busy;
    assign err_evt    = (cmp_evt && req_chk && data_mismatch(rd, req_exp, be)) || spur_evt;

    // Command storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, be: cmd_be,
                                            wd: cmd_wd, exp_data: cmd_exp, chk: cmd_chk};
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (cmd_push && cmd_full) overflow <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state, cache strobes and per-cycle event decode.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        hit_evt    = 1'b0;
        miss_evt   = 1'b0;
        cmp_evt    = 1'b0;
        spur_evt   = 1'b0;
        case (state)
            IDLE: begin
                spur_evt = rd_valid;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                read  = !req_wr;
                write = req_wr;
                if (req_hit) begin
                    hit_evt = 1'b1;
                    if (req_wr) begin
                        state_next = IDLE;
                    end else if (rd_valid) begin
                        cmp_evt    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_RD;
                    end
                end else begin
                    spur_evt = rd_valid;
                    miss_evt = req_miss && !missed;
                    if (tmo_cnt == TMO_LAST) state_next = ERR;
                end
            end
            WAIT_RD: begin
                if (rd_valid) begin
                    cmp_evt    = 1'b1;
                    state_next = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = ERR;
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-state cycle counter, cleared on every state change; sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            if (state_next != state)                tmo_cnt <= '0;
            else if (state == REQ || state == WAIT_RD) tmo_cnt <= tmo_cnt + 1'b1;
            if (state_next == ERR && state != ERR)  timeout <= 1'b1;
        end
    end

    // Request registers, loaded from the FIFO head on pop and held until the next pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a       <= '0;
            be      <= '0;
            wd      <= '0;
            req_wr  <= 1'b0;
            req_exp <= '0;
            req_chk <= 1'b0;
            missed  <= 1'b0;
        end else if (pop) begin
            a       <= head.addr;
            be      <= head.be;
            wd      <= head.wd;
            req_wr  <= head.write;
            req_exp <= head.exp_data;
            req_chk <= head.chk;
            missed  <= 1'b0;
        end else if (state == REQ && req_miss && !req_hit) begin
            missed  <= 1'b1;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (hit_evt)  hit_cnt  <= sat_inc(hit_cnt);
            if (miss_evt) miss_cnt <= sat_inc(miss_cnt);
            if (err_evt)  err_cnt  <= sat_inc(err_cnt);
        end
    end

endmodule
